alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 8-bit ALU between NREQ requesters, such as the execute stage and the branch/compare unit, so only one operation occupies the ALU at a time. It accepts one request per transaction using round-robin arbitration and latches that request's operands. It drives the ALU enable for exactly one cycle, captures the ALU's registered result and compare flag, and returns them to the winning requester over a valid/ready response channel. It sits between the requesting stages and the ALU and is the only driver of the ALU's enable, operand and function inputs.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- W, 8, operand/result width (matches ALU)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready
- req_x, req_y  in  NREQ×W  operands per requester
- req_funct  in  NREQ×4  ALU function code per requester
- resp_valid  out  NREQ  one-hot; result available for requester i
- resp_ready  in  NREQ  requester i consumes result
- resp_result  out  W  shared result bus, meaningful where resp_valid set
- resp_cmp  out  1  shared compare flag
- alu_en  out  1  ALU enable
- alu_x, alu_y  out  W  ALU operands
- alu_funct  out  4  ALU function
- alu_result  in  W  ALU registered result
- alu_cmp  in  1  ALU registered compare flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is asserted for exactly one requester: the round-robin winner among requesters with req_valid set.
  - On handshake, latch x/y/funct into alu_x/alu_y/alu_funct, record the owner index, and go to ISSUE.
- ISSUE: alu_en=1 for this single cycle, then go to WAIT.
- WAIT: alu_en=0. Capture alu_result into resp_result and alu_cmp into resp_cmp, then go to RESP.
- RESP:
  - resp_valid[owner]=1, all other bits 0.
  - resp_result and resp_cmp are held stable.
  - When resp_ready[owner]=1, go to IDLE.
- Round-robin pointer:
  - Reset value 0, so requester 0 has top priority after reset.
  - On each accept, the pointer becomes owner+1 mod NREQ.
  - Search order is pointer, pointer+1, … wrapping around.
- req_ready is 0 for all requesters in ISSUE, WAIT and RESP. Requests arriving then wait.
- A requester may drop req_valid before acceptance without penalty. The grant is recomputed every IDLE cycle.
- funct is passed through unmodified; the arbiter does not decode it. Codes the ALU does not implement return whatever the ALU holds.
- alu_x, alu_y and alu_funct are registered and hold their last value outside ISSUE.
- Reset (rst_n=0 sampled on a clock edge):
  - State goes to IDLE and the pointer to 0.
  - alu_en, req_ready, resp_valid, resp_result, resp_cmp, alu_x, alu_y and alu_funct all go to 0.
  - An in-flight operation is discarded and produces no response.

## Timing
- Accept edge E0 (IDLE, valid&ready).
- ISSUE in the cycle after E0. ALU registers its result at E1.
- WAIT captures the result at E2.
- resp_valid is high from E2 onward: 3 cycles after the accept cycle.
- Minimum transaction length is 4 cycles when resp_ready is already high: IDLE, ISSUE, WAIT, RESP.
- Maximum throughput is 1 operation per 4 cycles.
- req_ready is combinational from req_valid and the pointer, valid in IDLE only. All other outputs are registered.
- Simultaneous requests: exactly one grant per IDLE cycle, and a requester is never granted twice while another valid requester waits.
- Back-pressure: resp_valid and data are held indefinitely while resp_ready[owner]=0. resp_ready from non-owners is ignored.

## Structure
- Shared package (cirno_pkg):
  - ALU funct constants: ADD 0101, SUB 0100, SHL 1110, SHR 0111, XOR 0001, AND 0011, OR 0010, CMP 0110, SH 1010.
  - Data width constant (8).
  - alu_arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
- Sub-module rr_arbiter(NREQ): takes the req vector and pointer, returns a one-hot grant and the winner index. It is reused by later shared-resource controllers.

## Test plan
- Single request: req0 with x=5, y=3, funct=0101 → alu_en high exactly 1 cycle with alu_x=5, alu_y=3; resp_valid[0] 3 cycles after accept; resp_result=8.
- Contention: req0 and req1 valid every cycle, req0 with x=9,y=4,funct=0100 and req1 with x=0x0F,y=0xF0,funct=0001 → grants alternate 0,1,0,1; results 5 and 0xFF returned to the correct owner.
- Back-pressure: resp_ready[1]=0 for 10 cycles → resp_valid[1] and result held stable; req_ready stays 0; no second alu_en.
- Compare: x=7, y=7 with the CMP funct → resp_cmp reflects alu_cmp sampled in WAIT.
- Reset mid-operation: rst_n=0 during WAIT → next cycle all outputs 0, state IDLE; next grant goes to req0 even if req1 is also valid.

Source files
------------

// File: rtl/cirno_pkg.sv
// cirno_pkg: definitions shared by the ALU arbiter and the other controllers
// that sit in front of the shared 8-bit ALU.
//   - DataWidth       : ALU operand/result width
//   - Alu* constants  : ALU function codes, passed through undecoded
//   - alu_arb_state_t : ALU arbiter transaction states
package cirno_pkg;

    localparam int unsigned DataWidth = 8;

    localparam logic [3:0] AluAdd = 4'b0101;
    localparam logic [3:0] AluSub = 4'b0100;
    localparam logic [3:0] AluShl = 4'b1110;
    localparam logic [3:0] AluShr = 4'b0111;
    localparam logic [3:0] AluXor = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0011;
    localparam logic [3:0] AluOr  = 4'b0010;
    localparam logic [3:0] AluCmp = 4'b0110;
    localparam logic [3:0] AluSh  = 4'b1010;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } alu_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index of the highest-priority requester (must be < NREQ)
//   grant_o : one-hot grant, all zero when no request is set
//   idx_o   : index of the granted requester (0 when none)
// The search starts at ptr_i and wraps around.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand     = (32'(ptr_i) + off) % NREQ;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between NREQ requesters.
//   clk, rst_n                : clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake, req_ready one-hot (IDLE only)
//   req_x/req_y/req_funct     : packed per-requester operands and function
//   resp_valid/resp_ready     : one-hot response handshake to the owner
//   resp_result/resp_cmp      : shared response data, held while in RESP
//   alu_en/alu_x/alu_y/alu_funct : ALU drive, operands held outside ISSUE
//   alu_result/alu_cmp        : ALU registered outputs
// One transaction: IDLE (accept) -> ISSUE (alu_en) -> WAIT (capture) -> RESP.
module alu_arbiter
    import cirno_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = DataWidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ*4-1:0] req_funct,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_result,
    output logic              resp_cmp,
    output logic              alu_en,
    output logic [W-1:0]      alu_x,
    output logic [W-1:0]      alu_y,
    output logic [3:0]        alu_funct,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_cmp
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    alu_arb_state_t  state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic            alu_en_q, alu_en_d;
    logic [W-1:0]    alu_x_q, alu_x_d;
    logic [W-1:0]    alu_y_q, alu_y_d;
    logic [3:0]      alu_funct_q, alu_funct_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [W-1:0]    resp_result_q, resp_result_d;
    logic            resp_cmp_q, resp_cmp_d;

    logic [NREQ-1:0] grant;
    logic [IdxW-1:0] win_idx;
    logic            accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    // Grant only ever covers valid requesters, so any grant in IDLE is a handshake.
    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign accept    = (state_q == StIdle) && (|grant);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        alu_en_d      = 1'b0;
        alu_x_d       = alu_x_q;
        alu_y_d       = alu_y_q;
        alu_funct_d   = alu_funct_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_cmp_d    = resp_cmp_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_x_d     = req_x[win_idx*W +: W];
                    alu_y_d     = req_y[win_idx*W +: W];
                    alu_funct_d = req_funct[win_idx*4 +: 4];
                    owner_d     = win_idx;
                    ptr_d       = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    alu_en_d    = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // ALU registered its result at the end of ISSUE.
                resp_result_d = alu_result;
                resp_cmp_d    = alu_cmp;
                resp_valid_d  = NREQ'(1) << owner_q;
                state_d       = StResp;
            end
            StResp: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            owner_q       <= '0;
            alu_en_q      <= 1'b0;
            alu_x_q       <= '0;
            alu_y_q       <= '0;
            alu_funct_q   <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_cmp_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            alu_en_q      <= alu_en_d;
            alu_x_q       <= alu_x_d;
            alu_y_q       <= alu_y_d;
            alu_funct_q   <= alu_funct_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_cmp_q    <= resp_cmp_d;
        end
    end

    assign alu_en      = alu_en_q;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign alu_funct   = alu_funct_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_cmp    = resp_cmp_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*4-1:0] req_funct;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [W-1:0]      resp_result;
    logic              resp_cmp;
    logic              alu_en;
    logic [W-1:0]      alu_x;
    logic [W-1:0]      alu_y;
    logic [3:0]        alu_funct;
    logic [W-1:0]      alu_result;
    logic              alu_cmp;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_funct   (req_funct),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_cmp    (resp_cmp),
        .alu_en      (alu_en),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_funct   (alu_funct),
        .alu_result  (alu_result),
        .alu_cmp     (alu_cmp)
    );

    // Registered ALU model.
    always @(posedge clk) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_cmp    <= 1'b0;
        end else if (alu_en) begin
            case (alu_funct)
                4'b0101: alu_result <= alu_x + alu_y;
                4'b0100: alu_result <= alu_x - alu_y;
                4'b0001: alu_result <= alu_x ^ alu_y;
                4'b0011: alu_result <= alu_x & alu_y;
                4'b0010: alu_result <= alu_x | alu_y;
                4'b0110: alu_result <= alu_x - alu_y;
                default: alu_result <= 8'h00;
            endcase
            alu_cmp <= (alu_funct == 4'b0110) && (alu_x == alu_y);
        end
    end

    always @(posedge clk) begin
        if (alu_en) en_cnt <= en_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] f);
        req_x[idx*W +: W]   = x;
        req_y[idx*W +: W]   = y;
        req_funct[idx*4 +: 4] = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Single transaction by requester idx with resp_ready already high.
    task automatic run_op(input string tag, input int idx, input logic [7:0] x,
                          input logic [7:0] y, input logic [3:0] f,
                          input logic [7:0] exp_res, input logic exp_cmp);
        set_req(idx, x, y, f);
        req_valid  = 2'(1 << idx);
        resp_ready = 2'b11;
        #1;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid = '0;
        tick();
        tick();
        check_eq({tag, "_rvalid"}, 32'(resp_valid), 32'(1 << idx));
        check_eq({tag, "_result"}, 32'(resp_result), 32'(exp_res));
        check_eq({tag, "_cmp"}, 32'(resp_cmp), 32'(exp_cmp));
        tick();
        check_eq({tag, "_done"}, 32'(resp_valid), 32'd0);
        resp_ready = '0;
    endtask

    initial begin
        int en_base;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_funct  = '0;
        resp_ready = '0;
        do_reset();

        // Reset state.
        check_eq("rst_alu_en", 32'(alu_en), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_alu_x", 32'(alu_x), 32'd0);
        check_eq("rst_resp_result", 32'(resp_result), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);

        // Single request: 5 + 3.
        set_req(0, 8'd5, 8'd3, 4'b0101);
        req_valid = 2'b01;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_eq("single_en", 32'(alu_en), 32'd1);
        check_eq("single_x", 32'(alu_x), 32'd5);
        check_eq("single_y", 32'(alu_y), 32'd3);
        check_eq("single_funct", 32'(alu_funct), 32'h5);
        check_eq("single_busy_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("single_en_off", 32'(alu_en), 32'd0);
        check_eq("single_rv_early", 32'(resp_valid), 32'd0);
        tick();
        check_eq("single_rvalid", 32'(resp_valid), 32'h1);
        check_eq("single_result", 32'(resp_result), 32'd8);
        check_eq("single_en_cnt", 32'(en_cnt), 32'd1);
        resp_ready = 2'b01;
        tick();
        check_eq("single_done", 32'(resp_valid), 32'd0);
        resp_ready = '0;

        // Contention: both valid every cycle, grants alternate from 0.
        do_reset();
        set_req(0, 8'd9, 8'd4, 4'b0100);
        set_req(1, 8'h0F, 8'hF0, 4'b0001);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int t = 0; t < 4; t++) begin
            int exp_idx;
            exp_idx = t % 2;
            #1;
            check_eq("cont_grant", 32'(req_ready), 32'(1 << exp_idx));
            tick();
            tick();
            tick();
            check_eq("cont_rvalid", 32'(resp_valid), 32'(1 << exp_idx));
            check_eq("cont_result", 32'(resp_result), (exp_idx == 0) ? 32'h05 : 32'hFF);
            tick();
        end
        req_valid  = '0;
        resp_ready = '0;

        // Back-pressure on requester 1 (pointer is back at 0 here).
        set_req(1, 8'h0F, 8'hF0, 4'b0101);
        req_valid = 2'b10;
        #1;
        check_eq("bp_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        tick();
        en_base    = en_cnt;
        req_valid  = 2'b11;
        resp_ready = 2'b01;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_rvalid", 32'(resp_valid), 32'h2);
            check_eq("bp_result", 32'(resp_result), 32'hFF);
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        check_eq("bp_no_en", 32'(en_cnt), 32'(en_base));
        req_valid  = '0;
        resp_ready = 2'b10;
        tick();
        check_eq("bp_done", 32'(resp_valid), 32'd0);
        resp_ready = '0;

        // Compare flag.
        run_op("cmp_eq", 0, 8'd7, 8'd7, 4'b0110, 8'd0, 1'b1);
        run_op("cmp_ne", 1, 8'd7, 8'd3, 4'b0110, 8'd4, 1'b0);

        // Reset mid-operation (requester 1, reset asserted in WAIT).
        set_req(1, 8'h33, 8'h11, 4'b0011);
        req_valid = 2'b10;
        #1;
        check_eq("mid_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("mid_alu_en", 32'(alu_en), 32'd0);
        check_eq("mid_rvalid", 32'(resp_valid), 32'd0);
        check_eq("mid_result", 32'(resp_result), 32'd0);
        check_eq("mid_cmp", 32'(resp_cmp), 32'd0);
        check_eq("mid_alu_x", 32'(alu_x), 32'd0);
        check_eq("mid_alu_y", 32'(alu_y), 32'd0);
        check_eq("mid_funct", 32'(alu_funct), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("mid_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        check_eq("mid_regrant", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
